// File: rtl/sel_demux_if.sv
// Handshake and lane bundle for the 31-lane selector demultiplexer.
// The upstream side and the lane consumers use the master modport; the block uses slave.
interface sel_demux_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_data;
    logic [4:0]  in_sel;
    logic [61:0] out_data;
    logic [30:0] out_valid;
    logic [30:0] out_ready;
    logic [7:0]  drop_cnt;
    logic        drop_pulse;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt, drop_pulse
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_data, out_valid, drop_cnt, drop_pulse
    );
endinterface

// File: rtl/sel_demux.sv
// Routes 2-bit symbols into 31 independent one-entry lanes chosen by in_sel.
// Selector 31 discards the symbol and bumps a saturating drop counter.
module sel_demux (
    input logic        clk,
    input logic        rst_n,
    sel_demux_if.slave bus
);
    logic [30:0] valid_q, valid_d;
    logic [61:0] data_q, data_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        drop_pulse_q, drop_pulse_d;

    logic [31:0] valid_x;
    logic [31:0] ready_x;
    logic        is_drop;
    logic        accept;

    // Position 31 is a phantom lane that is always empty, so a drop is always accepted.
    assign valid_x = {1'b0, valid_q};
    assign ready_x = {1'b1, bus.out_ready};
    assign is_drop = (bus.in_sel == 5'd31);

    assign bus.in_ready = rst_n & (~valid_x[bus.in_sel] | ready_x[bus.in_sel]);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        valid_d      = valid_q & ~bus.out_ready;
        data_d       = data_q;
        drop_pulse_d = accept & is_drop;
        drop_cnt_d   = drop_cnt_q;
        for (int i = 0; i < 31; i++) begin
            if (accept && (bus.in_sel == 5'(i))) begin
                valid_d[i]        = 1'b1;
                data_d[2*i +: 2]  = bus.in_data;
            end
        end
        if (accept && is_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            data_q       <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_sel_demux.sv
// Scoreboard bench for sel_demux: the driver models lane occupancy and queues expected
// symbols per lane; a negedge monitor pops and compares whenever a lane drains.
module tb_sel_demux;
    logic clk;
    logic rst_n;

    sel_demux_if bus ();

    sel_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]  exp_q [31][$];
    logic [30:0] occ;
    int          exp_cnt;
    logic        exp_pulse;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 31; i++) exp_q[i].delete();
        occ       = '0;
        exp_cnt   = 0;
        exp_pulse = 1'b0;
    endtask

    // Called shortly after a rising edge; drives one cycle of stimulus and waits for the next edge.
    task automatic cycle(input logic v, input logic [4:0] s, input logic [1:0] d, input logic [30:0] r);
        logic pred_ready;
        logic acc;
        chk("out_valid", {33'b0, bus.out_valid}, {33'b0, occ});
        chk("drop_cnt", {56'b0, bus.drop_cnt}, 64'(exp_cnt));
        chk("drop_pulse", {63'b0, bus.drop_pulse}, {63'b0, exp_pulse});
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        pred_ready = (s == 5'd31) || !occ[s] || r[s];
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, pred_ready});
        acc = v && pred_ready;
        occ = occ & ~r;
        exp_pulse = 1'b0;
        if (acc && s != 5'd31) begin
            exp_q[s].push_back(d);
            occ[s] = 1'b1;
        end else if (acc) begin
            exp_pulse = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a lane with valid and ready at mid-cycle drains on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 31; i++) begin
                    if (bus.out_valid[i] && bus.out_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk("unexpected_drain", 64'(i), 64'd99);
                        end else begin
                            chk("lane_data", {62'b0, bus.out_data[2*i +: 2]}, {62'b0, exp_q[i].pop_front()});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [30:0] ones;
        logic [4:0]  rs;
        ones = '1;
        model_clear();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 5'd0;
        bus.in_data   = 2'd1;
        bus.out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {33'b0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {2'b0, bus.out_data}, 64'd0);
        rst_n = 1'b1;

        // Routing sweep: every lane gets sel[1:0], all consumers stalled.
        for (int i = 0; i < 31; i++) cycle(1'b1, 5'(i), 2'(i), '0);
        for (int i = 0; i < 31; i++) chk("route_data", {62'b0, bus.out_data[2*i +: 2]}, 64'(i % 4));
        cycle(1'b1, 5'd7, 2'd3, '0);
        cycle(1'b1, 5'd30, 2'd0, '0);
        cycle(1'b0, 5'd0, 2'd0, ones);
        cycle(1'b0, 5'd0, 2'd0, '0);

        // Back-to-back streaming on lane 5.
        cycle(1'b1, 5'd5, 2'd2, 31'(1 << 5));
        cycle(1'b1, 5'd5, 2'd1, 31'(1 << 5));
        cycle(1'b1, 5'd5, 2'd3, 31'(1 << 5));
        cycle(1'b1, 5'd5, 2'd0, 31'(1 << 5));
        cycle(1'b0, 5'd5, 2'd0, 31'(1 << 5));

        // Backpressure on lane 0.
        cycle(1'b1, 5'd0, 2'd1, '0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 5'd0, 2'd2, '0);
        chk("bp_hold", {62'b0, bus.out_data[1:0]}, 64'd1);
        cycle(1'b1, 5'd0, 2'd2, 31'd1);
        chk("bp_load", {62'b0, bus.out_data[1:0]}, 64'd2);
        cycle(1'b0, 5'd0, 2'd0, 31'd1);

        // Drop saturation.
        for (int k = 0; k < 300; k++) cycle(1'b1, 5'd31, 2'($urandom), 31'($urandom));
        cycle(1'b0, 5'd31, 2'd0, '0);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            rs = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            cycle($urandom_range(0, 3) != 0, rs, 2'($urandom), 31'($urandom));
        end

        // Mid-operation reset with lanes 3 and 30 full and seven drops recorded.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        cycle(1'b1, 5'd3, 2'd2, '0);
        cycle(1'b1, 5'd30, 2'd1, '0);
        for (int k = 0; k < 7; k++) cycle(1'b1, 5'd31, 2'd0, '0);
        cycle(1'b0, 5'd0, 2'd0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {33'b0, bus.out_valid}, 64'd0);
        chk("mid_rst_drop_cnt", {56'b0, bus.drop_cnt}, 64'd0);
        chk("mid_rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
        #3;
        rst_n = 1'b1;
        model_clear();
        cycle(1'b1, 5'd3, 2'd3, '0);
        chk("post_rst_lane3", {62'b0, bus.out_data[7:6]}, 64'd3);

        // Flush every lane so the monitor consumes all queued symbols.
        for (int k = 0; k < 3; k++) cycle(1'b0, 5'd0, 2'd0, ones);
        for (int i = 0; i < 31; i++) begin
            if (exp_q[i].size() != 0) chk("leftover", 64'(exp_q[i].size()), 64'd0);
        end
        chk("end_empty", {33'b0, bus.out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
